// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush scheduler: zero-latency hold vector and IF/ID flush from hazard, multi-cycle EX and MEM-wait requests.
// Optional cycle counters for stalls and flushes are compiled in with PIPE_CTRL_PERF_EN.
module pipe_stall_ctrl #(
  parameter int MC_CNT_W = 6,
  parameter int PERF_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_re1_i,
  input  logic                id_re2_i,
  input  logic [4:0]          id_raddr1_i,
  input  logic [4:0]          id_raddr2_i,
  input  logic                ex_memread_i,
  input  logic                ex_we_i,
  input  logic [4:0]          ex_waddr_i,
  input  logic                ex_mc_start_i,
  input  logic [MC_CNT_W-1:0] ex_mc_cycles_i,
  input  logic                mem_stallreq_i,
  input  logic                branch_taken_i,
  output logic [5:0]          stall_o,
  output logic                flush_o,
  output logic                busy_o,
  output logic [PERF_W-1:0]   perf_stall_cnt_o,
  output logic [PERF_W-1:0]   perf_flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MC_WAIT = 2'b01
  } state_t;

  localparam logic [5:0] STALL_LU  = 6'b000011;
  localparam logic [5:0] STALL_MC  = 6'b001111;
  localparam logic [5:0] STALL_MEM = 6'b011111;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [MC_CNT_W-1:0] r_cnt;
  logic [MC_CNT_W-1:0] w_cnt_nxt;
  logic                w_lu;
  logic                w_mc_hold;
  logic [5:0]          w_stall;
  logic                w_flush;

  // A load in EX feeding a register ID needs: one bubble, gone once the load moves on.
  assign w_lu = ex_memread_i & ex_we_i & (ex_waddr_i != 5'd0) &
                ((id_re1_i & (id_raddr1_i == ex_waddr_i)) |
                 (id_re2_i & (id_raddr2_i == ex_waddr_i)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mc_hold   = 1'b0;
    case (r_state)
      RUN: begin
        if (ex_mc_start_i && (ex_mc_cycles_i >= MC_CNT_W'(2))) begin
          w_mc_hold = 1'b1;
          // The start cycle is itself the first stall; N==2 needs nothing more.
          if (ex_mc_cycles_i > MC_CNT_W'(2)) begin
            w_cnt_nxt   = ex_mc_cycles_i - MC_CNT_W'(2);
            w_state_nxt = MC_WAIT;
          end
        end
      end
      MC_WAIT: begin
        w_mc_hold = 1'b1;
        w_cnt_nxt = r_cnt - MC_CNT_W'(1);
        if (r_cnt == MC_CNT_W'(1)) begin
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase

    w_stall = 6'b000000;
    if (w_mc_hold)      w_stall = w_stall | STALL_MC;
    if (w_lu)           w_stall = w_stall | STALL_LU;
    if (mem_stallreq_i) w_stall = w_stall | STALL_MEM;
    if (rst)            w_stall = 6'b000000;

    // A held IF/ID keeps the branch in ID; it re-resolves once released.
    w_flush = ~rst & branch_taken_i & ~w_stall[1];
  end

  assign stall_o = w_stall;
  assign flush_o = w_flush;
  assign busy_o  = ~rst & (r_state == MC_WAIT);

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] r_perf_stall;
  logic [PERF_W-1:0] r_perf_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_stall[0] && (r_perf_stall != {PERF_W{1'b1}})) begin
        r_perf_stall <= r_perf_stall + PERF_W'(1);
      end
      if (w_flush && (r_perf_flush != {PERF_W{1'b1}})) begin
        r_perf_flush <= r_perf_flush + PERF_W'(1);
      end
    end
  end

  assign perf_stall_cnt_o = r_perf_stall;
  assign perf_flush_cnt_o = r_perf_flush;
`else
  assign perf_stall_cnt_o = '0;
  assign perf_flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed vectors for pipe_stall_ctrl: one table row per clock cycle, plus a long multi-cycle run.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_re1_i, id_re2_i;
  logic [4:0]  id_raddr1_i, id_raddr2_i;
  logic        ex_memread_i, ex_we_i;
  logic [4:0]  ex_waddr_i;
  logic        ex_mc_start_i;
  logic [5:0]  ex_mc_cycles_i;
  logic        mem_stallreq_i, branch_taken_i;
  logic [5:0]  stall_o;
  logic        flush_o, busy_o;
  logic [31:0] perf_stall_cnt_o, perf_flush_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.MC_CNT_W(6), .PERF_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .id_re1_i         (id_re1_i),
    .id_re2_i         (id_re2_i),
    .id_raddr1_i      (id_raddr1_i),
    .id_raddr2_i      (id_raddr2_i),
    .ex_memread_i     (ex_memread_i),
    .ex_we_i          (ex_we_i),
    .ex_waddr_i       (ex_waddr_i),
    .ex_mc_start_i    (ex_mc_start_i),
    .ex_mc_cycles_i   (ex_mc_cycles_i),
    .mem_stallreq_i   (mem_stallreq_i),
    .branch_taken_i   (branch_taken_i),
    .stall_o          (stall_o),
    .flush_o          (flush_o),
    .busy_o           (busy_o),
    .perf_stall_cnt_o (perf_stall_cnt_o),
    .perf_flush_cnt_o (perf_flush_cnt_o)
  );

  typedef struct {
    logic       rst;
    logic       re1;
    logic [4:0] ra1;
    logic       re2;
    logic [4:0] ra2;
    logic       mr;
    logic       we;
    logic [4:0] wa;
    logic       mcs;
    logic [5:0] n;
    logic       mem;
    logic       br;
    logic [5:0] es;
    logic       ef;
    logic       eb;
  } vec_t;

  localparam int NV = 34;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic r, input logic re1, input logic [4:0] ra1,
                              input logic re2, input logic [4:0] ra2,
                              input logic mr, input logic we, input logic [4:0] wa,
                              input logic mcs, input logic [5:0] n,
                              input logic mem, input logic br,
                              input logic [5:0] es, input logic ef, input logic eb);
    vec_t v;
    v.rst = r;  v.re1 = re1; v.ra1 = ra1; v.re2 = re2; v.ra2 = ra2;
    v.mr = mr;  v.we = we;   v.wa = wa;   v.mcs = mcs; v.n = n;
    v.mem = mem; v.br = br;  v.es = es;   v.ef = ef;   v.eb = eb;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst            = v.rst;
    id_re1_i       = v.re1;
    id_raddr1_i    = v.ra1;
    id_re2_i       = v.re2;
    id_raddr2_i    = v.ra2;
    ex_memread_i   = v.mr;
    ex_we_i        = v.we;
    ex_waddr_i     = v.wa;
    ex_mc_start_i  = v.mcs;
    ex_mc_cycles_i = v.n;
    mem_stallreq_i = v.mem;
    branch_taken_i = v.br;
  endtask

  initial begin
    int m_stall;
    int m_flush;
    bit perf_ok;
    int st_cnt;
    int bz_cnt;
    bit done;
    vec_t idle;

    idle = mk(0, 0,0, 0,0, 0,0,0, 0,0, 0,0, 6'b000000,0,0);
    //            rst re1 ra1 re2 ra2 mr we wa mcs n  mem br  stall     fl bz
    vecs[0]  = mk(1,  0,0,   0,0,   0,0,0,   0,0,  1,1, 6'b000000,0,0);
    vecs[1]  = mk(0,  0,0,   0,0,   0,0,0,   0,0,  1,1, 6'b011111,0,0);
    vecs[2]  = idle;
    vecs[3]  = mk(0,  1,5,   0,0,   1,1,5,   0,0,  0,0, 6'b000011,0,0);
    vecs[4]  = idle;
    vecs[5]  = mk(0,  0,0,   1,7,   1,1,7,   0,0,  0,0, 6'b000011,0,0);
    vecs[6]  = mk(0,  1,0,   0,0,   1,1,0,   0,0,  0,0, 6'b000000,0,0);
    vecs[7]  = mk(0,  1,5,   0,0,   1,0,5,   0,0,  0,0, 6'b000000,0,0);
    vecs[8]  = mk(0,  0,0,   0,0,   0,0,0,   1,5,  0,0, 6'b001111,0,0);
    vecs[9]  = mk(0,  0,0,   0,0,   0,0,0,   1,5,  0,0, 6'b001111,0,1);
    vecs[10] = mk(0,  0,0,   0,0,   0,0,0,   0,0,  0,0, 6'b001111,0,1);
    vecs[11] = mk(0,  0,0,   0,0,   0,0,0,   0,0,  0,0, 6'b001111,0,1);
    vecs[12] = idle;
    vecs[13] = mk(0,  0,0,   0,0,   0,0,0,   1,2,  0,0, 6'b001111,0,0);
    vecs[14] = idle;
    vecs[15] = mk(0,  0,0,   0,0,   0,0,0,   1,1,  0,0, 6'b000000,0,0);
    vecs[16] = mk(0,  0,0,   0,0,   0,0,0,   1,0,  0,0, 6'b000000,0,0);
    vecs[17] = mk(0,  0,0,   0,0,   0,0,0,   0,0,  0,1, 6'b000000,1,0);
    vecs[18] = mk(0,  1,9,   0,0,   1,1,9,   0,0,  0,1, 6'b000011,0,0);
    vecs[19] = mk(0,  0,0,   0,0,   0,0,0,   1,3,  0,1, 6'b001111,0,0);
    vecs[20] = mk(0,  0,0,   0,0,   0,0,0,   0,0,  0,1, 6'b001111,0,1);
    vecs[21] = mk(0,  0,0,   0,0,   0,0,0,   0,0,  0,1, 6'b000000,1,0);
    vecs[22] = mk(0,  0,0,   0,0,   0,0,0,   1,6,  0,0, 6'b001111,0,0);
    vecs[23] = mk(0,  0,0,   0,0,   0,0,0,   0,0,  1,0, 6'b011111,0,1);
    vecs[24] = mk(0,  0,0,   0,0,   0,0,0,   0,0,  1,0, 6'b011111,0,1);
    vecs[25] = mk(0,  0,0,   0,0,   0,0,0,   0,0,  0,0, 6'b001111,0,1);
    vecs[26] = mk(0,  0,0,   0,0,   0,0,0,   0,0,  0,0, 6'b001111,0,1);
    vecs[27] = idle;
    vecs[28] = mk(0,  0,0,   0,0,   0,0,0,   1,5,  0,0, 6'b001111,0,0);
    vecs[29] = mk(0,  0,0,   0,0,   0,0,0,   0,0,  0,0, 6'b001111,0,1);
    vecs[30] = mk(1,  0,0,   0,0,   0,0,0,   0,0,  0,1, 6'b000000,0,0);
    vecs[31] = idle;
    vecs[32] = mk(0,  1,3,   0,0,   1,1,3,   0,0,  1,0, 6'b011111,0,0);
    vecs[33] = mk(0,  0,0,   1,4,   1,1,4,   1,2,  0,0, 6'b001111,0,0);

    apply(idle);
    rst = 1'b1;
    m_stall = 0;
    m_flush = 0;
    perf_ok = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i]);
      #2;
      chk("stall_o", i, {26'd0, stall_o}, {26'd0, vecs[i].es});
      chk("flush_o", i, {31'd0, flush_o}, {31'd0, vecs[i].ef});
      chk("busy_o",  i, {31'd0, busy_o},  {31'd0, vecs[i].eb});
      if (perf_ok) begin
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_stall", i, perf_stall_cnt_o, m_stall);
        chk("perf_flush", i, perf_flush_cnt_o, m_flush);
`else
        chk("perf_stall", i, perf_stall_cnt_o, 32'd0);
        chk("perf_flush", i, perf_flush_cnt_o, 32'd0);
`endif
      end
      @(posedge clk); #1;
      if (vecs[i].rst) begin
        m_stall = 0;
        m_flush = 0;
        perf_ok = 1'b1;
      end else begin
        if (vecs[i].es[0]) m_stall++;
        if (vecs[i].ef)    m_flush++;
      end
    end

    // Longest op the 6-bit length allows: 62 stalled cycles, 61 of them busy.
    apply(idle);
    ex_mc_start_i  = 1'b1;
    ex_mc_cycles_i = 6'd63;
    st_cnt = 0;
    bz_cnt = 0;
    done   = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      #2;
      if (stall_o == 6'b000000) begin
        done = 1'b1;
      end else begin
        if (stall_o == 6'b001111) st_cnt++;
        if (busy_o) bz_cnt++;
        @(posedge clk); #1;
        ex_mc_start_i = 1'b0;
      end
    end
    chk("long_mc_done",  0, {31'd0, done}, 32'd1);
    chk("long_mc_stall", 0, st_cnt, 32'd62);
    chk("long_mc_busy",  0, bz_cnt, 32'd61);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
